// File: rtl/scr1_imem_router_np_pkg.sv
// Shared types and default address map for the N-port IMEM router.
// Optional unmapped-error target: SCR1_IMEM_RT_UNMAPPED_ERR_EN.
`ifndef SCR1_IMEM_AWIDTH
`define SCR1_IMEM_AWIDTH 32
`endif
`ifndef SCR1_IMEM_DWIDTH
`define SCR1_IMEM_DWIDTH 32
`endif

package scr1_imem_router_np_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  // Sel code wide enough for up to 8 ports plus the internal error target.
  localparam int unsigned SCR1_IMEM_RT_PORT_MAX = 8;
  localparam int unsigned SCR1_IMEM_RT_SEL_W    = $clog2(SCR1_IMEM_RT_PORT_MAX + 1);

  typedef logic [SCR1_IMEM_RT_SEL_W-1:0] type_scr1_imem_rt_sel_t;

  // Index 0 sits in the LSBs: port0 = TCM, port1 = ROM, port2 = catch-all bus.
  localparam logic [3*`SCR1_IMEM_AWIDTH-1:0] SCR1_IMEM_RT_ADDR_MASK_DFLT = {
    `SCR1_IMEM_AWIDTH'(32'h0000_0000),
    `SCR1_IMEM_AWIDTH'(32'hFFFF_0000),
    `SCR1_IMEM_AWIDTH'(32'hFFFF_0000)
  };

  localparam logic [3*`SCR1_IMEM_AWIDTH-1:0] SCR1_IMEM_RT_ADDR_PATTERN_DFLT = {
    `SCR1_IMEM_AWIDTH'(32'h0000_0000),
    `SCR1_IMEM_AWIDTH'(32'h0048_0000),
    `SCR1_IMEM_AWIDTH'(32'h0001_0000)
  };

endpackage : scr1_imem_router_np_pkg

// File: rtl/scr1_imem_rt_sel_fifo.sv
// In-order FIFO of router sel codes; reports head, count and whether every
// live entry equals a compare code.
module scr1_imem_rt_sel_fifo
  import scr1_imem_router_np_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  type_scr1_imem_rt_sel_t       data_i,
  input  type_scr1_imem_rt_sel_t       cmp_i,
  output type_scr1_imem_rt_sel_t       head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic                         all_same_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  type_scr1_imem_rt_sel_t mem_q [DEPTH];
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PTR_W-1:0]       idx;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_i && pop_i) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Walk live entries from the head; stale slots beyond count are ignored.
  always_comb begin
    all_same_o = 1'b1;
    idx        = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = PTR_W'((32'(rd_ptr_q) + i) % DEPTH);
      if ((i < 32'(count_q)) && (mem_q[idx] != cmp_i)) begin
        all_same_o = 1'b0;
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule : scr1_imem_rt_sel_fifo

// File: rtl/scr1_imem_router_np.sv
// N-port IMEM router with in-order outstanding-request tracking.
// Define SCR1_IMEM_RT_UNMAPPED_ERR_EN to answer unmapped requests with RDY_ER.
module scr1_imem_router_np
  import scr1_imem_router_np_pkg::*;
#(
  parameter int unsigned                              PORT_NUM     = 3,
  parameter int unsigned                              OUTSTD_DEPTH = 2,
  parameter logic [PORT_NUM*`SCR1_IMEM_AWIDTH-1:0]    ADDR_MASK    = SCR1_IMEM_RT_ADDR_MASK_DFLT,
  parameter logic [PORT_NUM*`SCR1_IMEM_AWIDTH-1:0]    ADDR_PATTERN = SCR1_IMEM_RT_ADDR_PATTERN_DFLT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          imem_req_ack,
  input  logic                          imem_req,
  input  type_scr1_mem_cmd_e            imem_cmd,
  input  logic [`SCR1_IMEM_AWIDTH-1:0]  imem_addr,
  output logic [`SCR1_IMEM_DWIDTH-1:0]  imem_rdata,
  output type_scr1_mem_resp_e           imem_resp,
  input  logic [PORT_NUM-1:0]           port_req_ack,
  output logic [PORT_NUM-1:0]           port_req,
  output type_scr1_mem_cmd_e            port_cmd   [PORT_NUM-1:0],
  output logic [`SCR1_IMEM_AWIDTH-1:0]  port_addr  [PORT_NUM-1:0],
  input  logic [`SCR1_IMEM_DWIDTH-1:0]  port_rdata [PORT_NUM-1:0],
  input  type_scr1_mem_resp_e           port_resp  [PORT_NUM-1:0]
);

  localparam int unsigned AW    = `SCR1_IMEM_AWIDTH;
  localparam int unsigned DW    = `SCR1_IMEM_DWIDTH;
  localparam int unsigned SEL_W = SCR1_IMEM_RT_SEL_W;
  localparam int unsigned CNT_W = $clog2(OUTSTD_DEPTH + 1);

`ifdef SCR1_IMEM_RT_UNMAPPED_ERR_EN
  localparam type_scr1_imem_rt_sel_t SEL_ERR  = SEL_W'(PORT_NUM);
  localparam type_scr1_imem_rt_sel_t SEL_MISS = SEL_ERR;
`else
  localparam type_scr1_imem_rt_sel_t SEL_MISS = SEL_W'(PORT_NUM - 1);
`endif

  type_scr1_imem_rt_sel_t sel;
  logic                   hit_found;
  type_scr1_imem_rt_sel_t fifo_head;
  logic [CNT_W-1:0]       fifo_cnt;
  logic [CNT_W-1:0]       cnt_after;
  logic                   fifo_empty;
  logic                   fifo_all_same;
  logic                   live;
  logic                   pop;
  logic                   push;
  logic                   can_issue;
  logic                   sel_ack;
  type_scr1_mem_resp_e    head_resp;
  logic [DW-1:0]          head_rdata;

  always_comb begin
    sel       = SEL_MISS;
    hit_found = 1'b0;
    for (int unsigned i = 0; i < PORT_NUM; i++) begin
      if (!hit_found && ((imem_addr & ADDR_MASK[i*AW +: AW]) == ADDR_PATTERN[i*AW +: AW])) begin
        sel       = SEL_W'(i);
        hit_found = 1'b1;
      end
    end
  end

  scr1_imem_rt_sel_fifo #(
    .DEPTH (OUTSTD_DEPTH)
  ) i_sel_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .pop_i      (pop),
    .data_i     (sel),
    .cmp_i      (sel),
    .head_o     (fifo_head),
    .count_o    (fifo_cnt),
    .empty_o    (fifo_empty),
    .all_same_o (fifo_all_same)
  );

  // Gating with rst_n keeps the reset cycle quiet before the state clears.
  assign live = rst_n & ~fifo_empty;

  always_comb begin
    head_resp  = SCR1_MEM_RESP_NOTRDY;
    head_rdata = '0;
    if (live) begin
`ifdef SCR1_IMEM_RT_UNMAPPED_ERR_EN
      if (fifo_head == SEL_ERR) begin
        head_resp = SCR1_MEM_RESP_RDY_ER;
      end
`endif
      for (int unsigned i = 0; i < PORT_NUM; i++) begin
        if (fifo_head == SEL_W'(i)) begin
          head_resp  = port_resp[i];
          head_rdata = port_rdata[i];
        end
      end
    end
  end

  assign pop       = live & (head_resp != SCR1_MEM_RESP_NOTRDY);
  assign cnt_after = fifo_cnt - CNT_W'(pop);
  assign can_issue = rst_n & (cnt_after < CNT_W'(OUTSTD_DEPTH))
                   & (fifo_empty | fifo_all_same | (pop & (fifo_cnt == CNT_W'(1))));

  always_comb begin
    port_req = '0;
    sel_ack  = 1'b0;
`ifdef SCR1_IMEM_RT_UNMAPPED_ERR_EN
    if (sel == SEL_ERR) begin
      sel_ack = 1'b1;
    end
`endif
    for (int unsigned i = 0; i < PORT_NUM; i++) begin
      if (sel == SEL_W'(i)) begin
        port_req[i] = imem_req & can_issue;
        sel_ack     = port_req_ack[i];
      end
    end
  end

  assign imem_req_ack = sel_ack & can_issue;
  assign push         = imem_req & imem_req_ack;
  assign imem_resp    = head_resp;
  assign imem_rdata   = head_rdata;

  always_comb begin
    for (int unsigned i = 0; i < PORT_NUM; i++) begin
      port_cmd[i]  = imem_cmd;
      port_addr[i] = imem_addr;
    end
  end

endmodule : scr1_imem_router_np

// File: tb/tb_scr1_imem_router_np.sv
// Randomized scoreboard bench for scr1_imem_router_np (3 ports, depth 2).
module tb_scr1_imem_router_np;
  import scr1_imem_router_np_pkg::*;

  localparam int NP    = 3;
  localparam int DEPTH = 2;
`ifdef SCR1_IMEM_RT_UNMAPPED_ERR_EN
  localparam int MISS_CODE = NP;
`else
  localparam int MISS_CODE = NP - 1;
`endif

  // Port2 matches any address with top nibble 0, so overlaps with port0/1 test priority.
  localparam logic [NP*32-1:0] P_MASK = {32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_0000};
  localparam logic [NP*32-1:0] P_PATT = {32'h0000_0000, 32'h0048_0000, 32'h0001_0000};

  logic [31:0] m_mask [NP] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hF000_0000};
  logic [31:0] m_patt [NP] = '{32'h0001_0000, 32'h0048_0000, 32'h0000_0000};

  logic                clk = 1'b0;
  logic                rst_n;
  logic                imem_req_ack;
  logic                imem_req;
  type_scr1_mem_cmd_e  imem_cmd;
  logic [31:0]         imem_addr;
  logic [31:0]         imem_rdata;
  type_scr1_mem_resp_e imem_resp;
  logic [NP-1:0]       port_req_ack;
  logic [NP-1:0]       port_req;
  type_scr1_mem_cmd_e  port_cmd   [NP-1:0];
  logic [31:0]         port_addr  [NP-1:0];
  logic [31:0]         port_rdata [NP-1:0];
  type_scr1_mem_resp_e port_resp  [NP-1:0];

  scr1_imem_router_np #(
    .PORT_NUM     (NP),
    .OUTSTD_DEPTH (DEPTH),
    .ADDR_MASK    (P_MASK),
    .ADDR_PATTERN (P_PATT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req_ack (imem_req_ack),
    .imem_req     (imem_req),
    .imem_cmd     (imem_cmd),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .port_req_ack (port_req_ack),
    .port_req     (port_req),
    .port_cmd     (port_cmd),
    .port_addr    (port_addr),
    .port_rdata   (port_rdata),
    .port_resp    (port_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                  port;
    int                  ready;
    type_scr1_mem_resp_e resp;
    logic [31:0]         data;
  } pend_t;

  typedef struct {
    type_scr1_mem_resp_e resp;
    logic [31:0]         data;
  } exp_t;

  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;
  int          region   = 0;
  bit          stale    = 1'b0;
  logic [NP-1:0] delivered;
  int          outst [$];   // sel codes accepted and not yet answered, oldest first
  pend_t       pend  [$];   // slave-side responses still to be produced
  exp_t        sb    [$];   // expected core-side responses, in order

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NP; i++) begin
      if ((a & m_mask[i]) == m_patt[i]) return i;
    end
    return MISS_CODE;
  endfunction

  function automatic logic [31:0] addr_for(input int r);
    logic [31:0] off;
    off = {20'h0, $urandom_range(0, 4095) & 12'hFFC};
    case (r)
      0:       return 32'h0001_0000 | off;
      1:       return 32'h0048_0000 | off;
      2:       return 32'h0123_0000 | off;
      default: return 32'hF000_0000 | off;
    endcase
  endfunction

  task automatic drive();
    int idx;
    if ($urandom_range(0, 3) == 0) region = $urandom_range(0, 3);
    imem_req  = !stale && ($urandom_range(0, 99) < 75);
    imem_cmd  = ($urandom_range(0, 7) == 0) ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
    imem_addr = addr_for(region);
    delivered = '0;
    for (int i = 0; i < NP; i++) begin
      port_req_ack[i] = ($urandom_range(0, 3) != 0);
      idx = -1;
      for (int k = 0; k < pend.size(); k++) begin
        if (pend[k].port == i) begin
          idx = k;
          break;
        end
      end
      port_rdata[i] = $urandom;
      if (idx >= 0 && pend[idx].ready <= cyc) begin
        port_resp[i]  = pend[idx].resp;
        port_rdata[i] = pend[idx].data;
        delivered[i]  = 1'b1;
        pend.delete(idx);
      end else if (idx < 0 && $urandom_range(0, 3) == 0) begin
        port_resp[i] = SCR1_MEM_RESP_RDY_OK;  // idle port chatter that must be ignored
      end else begin
        port_resp[i] = SCR1_MEM_RESP_NOTRDY;
      end
    end
    if (stale && pend.size() == 0) stale = 1'b0;
  endtask

  task automatic check_update();
    int            sel;
    int            n_after;
    bit            pop_now;
    bit            same;
    bit            can;
    bit            exp_ack;
    logic [NP-1:0] exp_preq;
    int            k;
    exp_t          e;
    pend_t         p;
    sel = decode(imem_addr);
    k   = $urandom_range(0, NP - 1);
    chk("port_addr", port_addr[k], imem_addr);
    chk("port_cmd", 32'(port_cmd[k]), 32'(imem_cmd));
    if (!rst_n) begin
      chk("rst_ack", 32'(imem_req_ack), 32'd0);
      chk("rst_port_req", 32'(port_req), 32'd0);
      chk("rst_resp", 32'(imem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
      chk("rst_rdata", imem_rdata, 32'd0);
      outst.delete();
      sb.delete();
      stale = (pend.size() != 0);
      return;
    end
    pop_now = (outst.size() > 0) && (outst[0] == NP || delivered[outst[0]]);
    n_after = outst.size() - (pop_now ? 1 : 0);
    same    = 1'b1;
    foreach (outst[j]) if (outst[j] != sel) same = 1'b0;
    can      = (n_after < DEPTH) && (outst.size() == 0 || same || (pop_now && outst.size() == 1));
    exp_ack  = can && ((sel == NP) ? 1'b1 : port_req_ack[sel]);
    exp_preq = '0;
    if (imem_req && can && sel < NP) exp_preq[sel] = 1'b1;
    chk("req_ack", 32'(imem_req_ack), 32'(exp_ack));
    chk("port_req", 32'(port_req), 32'(exp_preq));
    if (outst.size() == 0) begin
      chk("idle_resp", 32'(imem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
      chk("idle_rdata", imem_rdata, 32'd0);
    end else begin
      chk("resp_valid", 32'(imem_resp != SCR1_MEM_RESP_NOTRDY), 32'(pop_now));
    end
    if (pop_now) void'(outst.pop_front());
    if (imem_req && exp_ack) begin
      outst.push_back(sel);
      if (sel == NP) begin
        e.resp = SCR1_MEM_RESP_RDY_ER;
        e.data = '0;
      end else begin
        p.port  = sel;
        p.ready = cyc + 1 + (($urandom_range(0, 9) == 0) ? 5 : $urandom_range(0, 3));
        p.resp  = ($urandom_range(0, 6) == 0) ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
        p.data  = $urandom;
        pend.push_back(p);
        e.resp  = p.resp;
        e.data  = p.data;
      end
      sb.push_back(e);
    end
  endtask

  // Monitor: consumes one expected entry per response the router presents.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && imem_resp != SCR1_MEM_RESP_NOTRDY) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL resp_unexpected cyc=%0d: got resp %0d expected none", cyc, imem_resp);
      end else begin
        n_checks--;
        e = sb.pop_front();
        chk("resp_code", 32'(imem_resp), 32'(e.resp));
        chk("resp_rdata", imem_rdata, e.data);
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    imem_req     = 1'b0;
    imem_cmd     = SCR1_MEM_CMD_RD;
    imem_addr    = '0;
    port_req_ack = '0;
    delivered    = '0;
    for (int i = 0; i < NP; i++) begin
      port_resp[i]  = SCR1_MEM_RESP_NOTRDY;
      port_rdata[i] = '0;
    end
    for (int n = 0; n < 1600; n++) begin
      @(posedge clk);
      #1;
      cyc++;
      rst_n = !(cyc < 3 || cyc == 800 || cyc == 801);
      drive();
      @(negedge clk);
      check_update();
    end
    for (int n = 0; n < 60; n++) begin
      @(posedge clk);
      #1;
      cyc++;
      drive();
      imem_req = 1'b0;
      @(negedge clk);
      check_update();
    end
    chk("drain_outstanding", 32'(outst.size()), 32'd0);
    chk("drain_scoreboard", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule : tb_scr1_imem_router_np
